bp_choice_queue: RTL and testbench



---
 rtl/bp_choice_queue_pkg.sv | 64 ++++++
 rtl/bp_choice_fifo.sv | 104 ++++++++++
 rtl/bp_choice_queue.sv | 161 ++++++++++++++++
 tb/tb_bp_choice_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_choice_queue_pkg.sv
// -----------------------------------------------------------------------------
// bp_choice_queue_pkg
//
// Shared definitions for the tournament chooser path: the prediction and
// resolved-branch structs, the per-fetch-block checkpoint entry, and the
// address-split constants used by the chooser, the BHT and the checkpoint
// queue.
//
// Core configuration (virtual address width, fetch width, compressed ISA)
// is fixed here so that every consumer of these types agrees on the layout.
// -----------------------------------------------------------------------------
package bp_choice_queue_pkg;

  // Core configuration.
  localparam int unsigned VLEN            = 32;
  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam bit          RVC             = 1'b1;

  // Byte offset of an instruction slot inside a fetch block, and the number
  // of slot-index bits above it.
  localparam int unsigned OFFSET        = RVC ? 1 : 2;
  localparam int unsigned ROW_ADDR_BITS = $clog2(INSTR_PER_FETCH);

  // Lowest pc bit that belongs to the fetch-block address.
  localparam int unsigned BLK_LSB    = ROW_ADDR_BITS + OFFSET;
  localparam int unsigned BLK_ADDR_W = VLEN - BLK_LSB;

  typedef logic [INSTR_PER_FETCH-1:0] slot_mask_t;
  typedef logic [ROW_ADDR_BITS-1:0]   slot_idx_t;
  typedef logic [BLK_ADDR_W-1:0]      blk_addr_t;

  // Resolved conditional branch coming back from the backend.
  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] pc;
    logic            taken;
  } bht_update_t;

  // Single-slot direction prediction.
  typedef struct packed {
    logic valid;
    logic taken;
  } bht_prediction_t;

  typedef bht_prediction_t [INSTR_PER_FETCH-1:0] pred_array_t;

  // One checkpoint: which block, which slots still await resolution, and
  // what each component predictor said for every slot of that block.
  typedef struct packed {
    blk_addr_t   blk_addr;
    slot_mask_t  pending;
    pred_array_t gbp;
    pred_array_t lbp;
  } bp_choice_entry_t;

  // One-hot mask for a slot index.
  function automatic slot_mask_t slot_onehot(input slot_idx_t slot);
    slot_mask_t mask;
    mask = '0;
    mask[slot] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/bp_choice_fifo.sv
// -----------------------------------------------------------------------------
// bp_choice_fifo
//
// Checkpoint storage for bp_choice_queue: a DEPTH-entry circular buffer of
// bp_choice_entry_t with a combinationally visible head, so the resolve
// logic can compare and replay in the same cycle the update arrives.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         drop every entry; wins over push, pop and mask clear
//   push_i          write push_entry_i at the tail (caller guarantees room,
//                   or a simultaneous pop)
//   pop_i           retire the head entry
//   clr_i           clear clr_mask_i bits in the head's pending mask
//   head_o          head entry, all-zero while empty
//   empty_o/full_o  occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module bp_choice_fifo
  import bp_choice_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  bp_choice_entry_t push_entry_i,
  input  logic             pop_i,
  input  logic             clr_i,
  input  slot_mask_t       clr_mask_i,
  output bp_choice_entry_t head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  bp_choice_entry_t entry_q [DEPTH];
  bp_choice_entry_t entry_d [DEPTH];

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

  // Empty slots may hold stale or never-written data, so the head is masked
  // rather than relying on the storage having been reset.
  assign head_o = empty_o ? '0 : entry_q[rd_ptr_q];

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
      count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage next-state. A push into the head slot can only coincide with a
  // mask clear when the buffer is full and popping, in which case the new
  // entry must win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (!flush_i) begin
        if (push_i && (wr_ptr_q == PTR_W'(i))) begin
          entry_d[i] = push_entry_i;
        end else if (clr_i && (rd_ptr_q == PTR_W'(i))) begin
          entry_d[i].pending = entry_q[i].pending & ~clr_mask_i;
        end
      end
    end
  end

  // Payload needs no reset: validity is carried entirely by the count.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: rtl/bp_choice_queue.sv
// -----------------------------------------------------------------------------
// bp_choice_queue
//
// Tournament combiner plus checkpoint queue. Each cycle it merges the global
// and local predictions into the final per-slot prediction using the
// chooser's select bits. Fetch blocks that contain a conditional branch are
// checkpointed (block address, pending-slot mask, both prediction arrays);
// when a branch resolves, the matching head checkpoint is replayed to the
// chooser's update inputs.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   flush_i                  discard all checkpoints
//   vpc_i, push_i, cf_mask_i fetch block accepted by the frontend
//   gbp_pred_i, lbp_pred_i   component predictions for the fetch block
//   select_prediction_i      per slot: 1 = global, 0 = local
//   pred_o                   final per-slot prediction (combinational)
//   full_o                   checkpoint queue full, frontend must stall
//   bht_update_i             resolved conditional branch
//   update_gbp_pred_o,
//   update_lbp_pred_o        stored predictions for the resolving block
//   update_hit_o             resolving branch matched the head checkpoint
// -----------------------------------------------------------------------------
module bp_choice_queue
  import bp_choice_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [VLEN-1:0] vpc_i,
  input  logic        push_i,
  input  slot_mask_t  cf_mask_i,
  input  pred_array_t gbp_pred_i,
  input  pred_array_t lbp_pred_i,
  input  slot_mask_t  select_prediction_i,
  output pred_array_t pred_o,
  output logic        full_o,
  input  bht_update_t bht_update_i,
  output pred_array_t update_gbp_pred_o,
  output pred_array_t update_lbp_pred_o,
  output logic        update_hit_o
);

  // ---------------------------------------------------------------------------
  // Final prediction: take the chosen component, fall back to the other one
  // if the chosen one has nothing to say, and emit all-zero if neither does.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_select
    bht_prediction_t chosen;
    bht_prediction_t other;

    assign chosen = select_prediction_i[gi] ? gbp_pred_i[gi] : lbp_pred_i[gi];
    assign other  = select_prediction_i[gi] ? lbp_pred_i[gi] : gbp_pred_i[gi];

    always_comb begin
      pred_o[gi] = '0;
      if (chosen.valid) begin
        pred_o[gi] = chosen;
      end else if (other.valid) begin
        pred_o[gi] = other;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checkpoint queue
  // ---------------------------------------------------------------------------
  bp_choice_entry_t push_entry;
  bp_choice_entry_t head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push_ok;
  logic             pop;
  logic             clr;
  slot_mask_t       clr_mask;

  assign push_entry.blk_addr = vpc_i[VLEN-1:BLK_LSB];
  assign push_entry.pending  = cf_mask_i;
  assign push_entry.gbp      = gbp_pred_i;
  assign push_entry.lbp      = lbp_pred_i;

  // Resolve decode. Without compressed instructions every branch pc is
  // treated as slot 0 of its block.
  blk_addr_t  upd_blk_addr;
  slot_idx_t  upd_slot;
  slot_mask_t upd_slot_mask;
  logic       head_addr_eq;
  logic       res_hit;
  logic       res_stale;
  logic       last_pending;

  assign upd_blk_addr = bht_update_i.pc[VLEN-1:BLK_LSB];
  assign upd_slot     = RVC ? bht_update_i.pc[BLK_LSB-1:OFFSET] : '0;
  assign upd_slot_mask = slot_onehot(upd_slot);
  assign head_addr_eq = (head.blk_addr == upd_blk_addr);

  // A flush in the same cycle turns any resolve into a reported miss and
  // suppresses its side effects on the queue.
  assign res_hit = bht_update_i.valid && !flush_i && !fifo_empty &&
                   head_addr_eq && ((head.pending & upd_slot_mask) != '0);

  // Head belongs to a block that never resolves (wrong path): drop it so the
  // queue cannot stall behind it. Same address with a non-pending slot is a
  // duplicate resolve and leaves the head in place.
  assign res_stale = bht_update_i.valid && !flush_i && !fifo_empty && !head_addr_eq;

  assign last_pending = ((head.pending & ~upd_slot_mask) == '0);

  assign clr      = res_hit;
  assign clr_mask = upd_slot_mask;
  assign pop      = (res_hit && last_pending) || res_stale;

  // A pop in the same cycle frees a slot, so a push is accepted even when
  // the registered count says full.
  assign push_ok = push_i && (cf_mask_i != '0) && !flush_i && (!fifo_full || pop);

  bp_choice_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .push_i       (push_ok),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .clr_i        (clr),
    .clr_mask_i   (clr_mask),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  assign full_o = fifo_full;

  // ---------------------------------------------------------------------------
  // Chooser update outputs. On a miss the arrays are zeroed so every valid
  // bit is low and the chooser leaves its counters alone. With no update in
  // flight the head is shown as-is (zero when empty).
  // ---------------------------------------------------------------------------
  always_comb begin
    update_hit_o      = 1'b0;
    update_gbp_pred_o = '0;
    update_lbp_pred_o = '0;
    if (!bht_update_i.valid) begin
      update_gbp_pred_o = head.gbp;
      update_lbp_pred_o = head.lbp;
    end else if (res_hit) begin
      update_hit_o      = 1'b1;
      update_gbp_pred_o = head.gbp;
      update_lbp_pred_o = head.lbp;
    end
  end

  // Low address bits and the resolved direction are not needed here.
  logic unused_bits;
  assign unused_bits = ^{bht_update_i.taken, bht_update_i.pc[OFFSET-1:0],
                         vpc_i[BLK_LSB-1:0]};

endmodule

// File: tb/tb_bp_choice_queue.sv
module tb_bp_choice_queue;
  import bp_choice_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic [VLEN-1:0] vpc_i = '0;
  logic        push_i = 1'b0;
  slot_mask_t  cf_mask_i = '0;
  pred_array_t gbp_pred_i = '0;
  pred_array_t lbp_pred_i = '0;
  slot_mask_t  select_prediction_i = '0;
  pred_array_t pred_o;
  logic        full_o;
  bht_update_t bht_update_i = '0;
  pred_array_t update_gbp_pred_o;
  pred_array_t update_lbp_pred_o;
  logic        update_hit_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bp_choice_queue #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .vpc_i               (vpc_i),
    .push_i              (push_i),
    .cf_mask_i           (cf_mask_i),
    .gbp_pred_i          (gbp_pred_i),
    .lbp_pred_i          (lbp_pred_i),
    .select_prediction_i (select_prediction_i),
    .pred_o              (pred_o),
    .full_o              (full_o),
    .bht_update_i        (bht_update_i),
    .update_gbp_pred_o   (update_gbp_pred_o),
    .update_lbp_pred_o   (update_lbp_pred_o),
    .update_hit_o        (update_hit_o)
  );

  // Select-mux vectors: pred bits are {slot1.valid, slot1.taken, slot0.valid, slot0.taken}.
  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] g;
    logic [3:0] l;
    logic [3:0] exp_pred;
  } mux_vec_t;

  mux_vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    push_i       = 1'b0;
    cf_mask_i    = '0;
    flush_i      = 1'b0;
    bht_update_i = '0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic [1:0] mask,
                          input logic [3:0] g, input logic [3:0] l);
    vpc_i      = pc;
    push_i     = 1'b1;
    cf_mask_i  = mask;
    gbp_pred_i = g;
    lbp_pred_i = l;
  endtask

  task automatic push_blk(input logic [31:0] pc, input logic [1:0] mask,
                          input logic [3:0] g, input logic [3:0] l);
    set_push(pc, mask, g, l);
    $display("push    pc=%h mask=%b g=%b l=%b full=%0b", pc, mask, g, l, full_o);
    tick();
    idle();
  endtask

  // Resolve pc this cycle (alongside any push already set up) and check the
  // combinational replay before the edge.
  task automatic resolve(input string name, input logic [31:0] pc, input logic exp_hit,
                         input logic [3:0] eg, input logic [3:0] el);
    bht_update_i.valid = 1'b1;
    bht_update_i.pc    = pc;
    bht_update_i.taken = 1'b1;
    #1;
    chk({name, ".hit"}, 32'(update_hit_o), 32'(exp_hit));
    chk({name, ".gbp"}, 32'(update_gbp_pred_o), 32'(eg));
    chk({name, ".lbp"}, 32'(update_lbp_pred_o), 32'(el));
    $display("resolve pc=%h hit=%0b g=%b l=%b push=%0b flush=%0b",
             pc, update_hit_o, update_gbp_pred_o, update_lbp_pred_o, push_i, flush_i);
    tick();
    idle();
  endtask

  // No update in flight: outputs show the head (zero when empty).
  task automatic peek(input string name, input logic [3:0] eg, input logic [3:0] el);
    bht_update_i = '0;
    #1;
    chk({name, ".hit"}, 32'(update_hit_o), 32'(0));
    chk({name, ".gbp"}, 32'(update_gbp_pred_o), 32'(eg));
    chk({name, ".lbp"}, 32'(update_lbp_pred_o), 32'(el));
  endtask

  initial begin
    logic [3:0] kk;

    vecs[0] = '{sel: 2'b11, g: 4'b1111, l: 4'b1010, exp_pred: 4'b1111};
    vecs[1] = '{sel: 2'b00, g: 4'b1111, l: 4'b1010, exp_pred: 4'b1010};
    vecs[2] = '{sel: 2'b11, g: 4'b0101, l: 4'b1111, exp_pred: 4'b1111};
    vecs[3] = '{sel: 2'b00, g: 4'b1111, l: 4'b0000, exp_pred: 4'b1111};
    vecs[4] = '{sel: 2'b11, g: 4'b0101, l: 4'b0101, exp_pred: 4'b0000};
    vecs[5] = '{sel: 2'b10, g: 4'b1011, l: 4'b1110, exp_pred: 4'b1010};
    vecs[6] = '{sel: 2'b01, g: 4'b1011, l: 4'b1110, exp_pred: 4'b1111};
    vecs[7] = '{sel: 2'b11, g: 4'b1000, l: 4'b0011, exp_pred: 4'b1011};

    // Reset state, with a resolve presented against the empty queue.
    bht_update_i.valid = 1'b1;
    bht_update_i.pc    = 32'h1000;
    #2;
    chk("rst.full", 32'(full_o), 32'(0));
    chk("rst.hit", 32'(update_hit_o), 32'(0));
    chk("rst.gbp", 32'(update_gbp_pred_o), 32'(0));
    chk("rst.lbp", 32'(update_lbp_pred_o), 32'(0));
    idle();
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // Select mux table.
    for (int i = 0; i < 8; i++) begin
      select_prediction_i = vecs[i].sel;
      gbp_pred_i          = vecs[i].g;
      lbp_pred_i          = vecs[i].l;
      #1;
      chk($sformatf("mux%0d", i), 32'(pred_o), 32'(vecs[i].exp_pred));
      $display("mux     sel=%b g=%b l=%b pred=%b", vecs[i].sel, vecs[i].g, vecs[i].l, pred_o);
    end
    tick();

    // In-order replay.
    push_blk(32'h1000, 2'b01, 4'b0011, 4'b0010);
    push_blk(32'h1004, 2'b10, 4'b1100, 4'b1000);
    peek("io.head0", 4'b0011, 4'b0010);
    resolve("io.r1000", 32'h1000, 1'b1, 4'b0011, 4'b0010);
    peek("io.head1", 4'b1100, 4'b1000);
    resolve("io.r1006", 32'h1006, 1'b1, 4'b1100, 4'b1000);
    peek("io.empty", 4'b0000, 4'b0000);

    // Two-branch block: stays until both slots resolve; a repeat resolve misses.
    push_blk(32'h1010, 2'b11, 4'b1111, 4'b1010);
    resolve("tb.s0", 32'h1010, 1'b1, 4'b1111, 4'b1010);
    peek("tb.stay", 4'b1111, 4'b1010);
    resolve("tb.dup", 32'h1010, 1'b0, 4'b0000, 4'b0000);
    peek("tb.stay2", 4'b1111, 4'b1010);
    resolve("tb.s1", 32'h1012, 1'b1, 4'b1111, 4'b1010);
    peek("tb.empty", 4'b0000, 4'b0000);

    // Push of a block without conditional branches is not enqueued.
    push_blk(32'h1800, 2'b00, 4'b1111, 4'b1111);
    peek("nocf.empty", 4'b0000, 4'b0000);

    // Stale head dropped.
    push_blk(32'h2000, 2'b01, 4'b0011, 4'b0011);
    peek("st.head", 4'b0011, 4'b0011);
    resolve("st.miss", 32'h3000, 1'b0, 4'b0000, 4'b0000);
    peek("st.empty", 4'b0000, 4'b0000);

    // Fill to full, ignored 9th push, push with hit-pop while full, drain.
    for (int k = 0; k < 8; k++) begin
      kk = 4'(k);
      chk($sformatf("fill%0d.full", k), 32'(full_o), 32'(0));
      push_blk(32'h4000 + 32'(4 * k), 2'b01, kk, ~kk);
    end
    chk("full.set", 32'(full_o), 32'(1));
    push_blk(32'h6000, 2'b01, 4'hF, 4'hF);
    chk("full.hold", 32'(full_o), 32'(1));
    set_push(32'h5000, 2'b01, 4'h8, 4'h7);
    resolve("full.pp", 32'h4000, 1'b1, 4'h0, 4'hF);
    chk("full.after_pp", 32'(full_o), 32'(1));
    for (int k = 1; k < 8; k++) begin
      kk = 4'(k);
      resolve($sformatf("drain%0d", k), 32'h4000 + 32'(4 * k), 1'b1, kk, ~kk);
      chk($sformatf("drain%0d.full", k), 32'(full_o), 32'(0));
    end
    resolve("drain.last", 32'h5000, 1'b1, 4'h8, 4'h7);
    peek("drain.empty", 4'b0000, 4'b0000);

    // Pointer wrap: 20 cycles of simultaneous push and hit-pop.
    push_blk(32'h7000, 2'b01, 4'h0, 4'hF);
    for (int i = 1; i <= 20; i++) begin
      kk = 4'(i - 1);
      set_push(32'h7000 + 32'(4 * i), 2'b01, 4'(i), ~4'(i));
      resolve($sformatf("wrap%0d", i), 32'h7000 + 32'(4 * (i - 1)), 1'b1, kk, ~kk);
    end
    resolve("wrap.last", 32'h7050, 1'b1, 4'h4, 4'hB);
    peek("wrap.empty", 4'b0000, 4'b0000);

    // Flush beats push and resolve in the same cycle.
    push_blk(32'h8000, 2'b01, 4'b0011, 4'b0011);
    push_blk(32'h8004, 2'b01, 4'b0110, 4'b0110);
    flush_i = 1'b1;
    set_push(32'h8008, 2'b01, 4'b1100, 4'b1100);
    resolve("fl.res", 32'h8000, 1'b0, 4'b0000, 4'b0000);
    peek("fl.empty", 4'b0000, 4'b0000);
    chk("fl.full", 32'(full_o), 32'(0));
    resolve("fl.after", 32'h8008, 1'b0, 4'b0000, 4'b0000);

    // Asynchronous reset mid-stream.
    for (int k = 0; k < 8; k++) begin
      push_blk(32'h9000 + 32'(4 * k), 2'b01, 4'b0011, 4'b0011);
    end
    chk("ar.full_before", 32'(full_o), 32'(1));
    bht_update_i.valid = 1'b1;
    bht_update_i.pc    = 32'h9000;
    #1;
    chk("ar.hit_before", 32'(update_hit_o), 32'(1));
    rst_ni = 1'b0;
    #1;
    chk("ar.full", 32'(full_o), 32'(0));
    chk("ar.hit", 32'(update_hit_o), 32'(0));
    chk("ar.gbp", 32'(update_gbp_pred_o), 32'(0));
    idle();
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    peek("ar.empty", 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
